// File: rtl/ana_serial_pkg.sv
// Shared definitions for the analog-interface serial controller.
//   - state_t   : controller state encoding
//   - DEF_*     : default widths for the parallel words and the length field
//   - eff_len() : maps a requested transfer length onto the real one
package ana_serial_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GAPA  = 3'd1,
        S_PH1   = 3'd2,
        S_GAPB  = 3'd3,
        S_PH2   = 3'd4,
        S_GAPL  = 3'd5,
        S_LATCH = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // A length of 0, or one longer than the word, means "the whole word".
    function automatic int eff_len(input int nbits, input int width);
        return ((nbits == 0) || (nbits > width)) ? width : nbits;
    endfunction

endpackage

// File: rtl/ana_phase_timer.sv
// Phase timer: down-counter that measures the CLK_DIV-cycle high phases
// (PH1, PH2, LATCH) of the serial controller.
//   CLK   : system clock
//   RST   : asynchronous active-high reset
//   load  : reload with CLK_DIV-1 (asserted in the gap cycle before a phase)
//   en    : count down while inside a timed phase
//   last  : high during the final cycle of the current timed phase
module ana_phase_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [TW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TW'(CLK_DIV - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/ana_serial_ctrl.sv
// Analog-interface serial controller. Shifts a configuration word out to the
// analog front-end with two non-overlapping shift clocks, pulses the latch,
// and captures the readback bits of the scan chain into a parallel word.
//   CLK, RST      : clock, asynchronous active-high reset
//   START         : transfer request, honoured in IDLE or DONE only
//   DIN, NBITS    : right-aligned word to send and its length (0/oversize = full)
//   DOUT, RDY     : captured readback word, valid while RDY is high
//   BUSY, SEL     : high for the whole transfer, up to the fall of LAT
//   SO, SI        : serial data to / from the analog chain
//   SCLK1, SCLK2  : phase-1 / phase-2 shift clocks
//   LAT           : latch pulse after the last bit
module ana_serial_ctrl
    import ana_serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int CLK_DIV    = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic [CNT_WIDTH-1:0]  NBITS,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  BUSY,
    output logic                  RDY,
    output logic                  SEL,
    output logic                  SO,
    input  logic                  SI,
    output logic                  SCLK1,
    output logic                  SCLK2,
    output logic                  LAT
);

    state_t                state, state_next;
    logic                  accept;
    logic                  tmr_last;
    logic                  tmr_load;
    logic                  tmr_en;
    logic                  bit_end;
    logic [CNT_WIDTH-1:0]  n_eff;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] sh_al;
    logic [DATA_WIDTH-1:0] cap;

    assign n_eff = CNT_WIDTH'(eff_len(int'(NBITS), DATA_WIDTH));
    // Left-align the field so the first bit to send is always the word MSB.
    assign sh_al = DIN << (DATA_WIDTH - int'(n_eff));

    // Every timed phase is preceded by exactly one gap cycle, which reloads the timer.
    assign tmr_load = (state == S_GAPA) || (state == S_GAPB) || (state == S_GAPL);
    assign tmr_en   = (state == S_PH1) || (state == S_PH2) || (state == S_LATCH);
    assign bit_end  = (state == S_PH2) && tmr_last;

    ana_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .load (tmr_load),
        .en   (tmr_en),
        .last (tmr_last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_next = S_GAPA;
                    accept     = 1'b1;
                end
            end
            S_GAPA:  state_next = S_PH1;
            S_PH1:   if (tmr_last) state_next = S_GAPB;
            S_GAPB:  state_next = S_PH2;
            S_PH2:   if (tmr_last) state_next = (bit_cnt > CNT_WIDTH'(1)) ? S_GAPA : S_GAPL;
            S_GAPL:  state_next = S_LATCH;
            S_LATCH: if (tmr_last) state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // changes exactly on the edge that enters or leaves its phase.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            BUSY    <= 1'b0;
            SEL     <= 1'b0;
            RDY     <= 1'b0;
            SCLK1   <= 1'b0;
            SCLK2   <= 1'b0;
            LAT     <= 1'b0;
            SO      <= 1'b0;
            DOUT    <= '0;
            sh      <= '0;
            cap     <= '0;
            bit_cnt <= '0;
        end else begin
            BUSY  <= (state_next != S_IDLE) && (state_next != S_DONE);
            SEL   <= (state_next != S_IDLE) && (state_next != S_DONE);
            RDY   <= (state_next == S_DONE);
            SCLK1 <= (state_next == S_PH1);
            SCLK2 <= (state_next == S_PH2);
            LAT   <= (state_next == S_LATCH);

            if (accept) begin
                SO      <= sh_al[DATA_WIDTH-1];
                sh      <= sh_al << 1;
                cap     <= '0;
                bit_cnt <= n_eff;
            end else if (bit_end) begin
                cap     <= {cap[DATA_WIDTH-2:0], SI};
                bit_cnt <= bit_cnt - CNT_WIDTH'(1);
                // After the final bit SO keeps its value until the next START.
                if (bit_cnt > CNT_WIDTH'(1)) begin
                    SO <= sh[DATA_WIDTH-1];
                    sh <= sh << 1;
                end
            end

            if ((state == S_LATCH) && tmr_last) begin
                DOUT <= cap;
            end
        end
    end

endmodule

// File: doc/ana_serial_ctrl.md
Name: ana_serial_ctrl

Overview:
- Analog-interface serial controller. Sits downstream of the CPU I/O registers (io_control, io_dataoutA) and upstream of the io_datainA/io_status read path.
- Shifts a CPU-supplied configuration word out to the analog front-end using two-phase non-overlapping shift clocks (SCLK1/SCLK2), then pulses the latch (LAT).
- Captures readback bits (e.g. the ADC result) from the analog scan chain during the same transfer and returns them to the CPU as a parallel word with a ready flag.

Parameters:
- DATA_WIDTH, 16, width of the parallel in/out words and the maximum transfer length.
- CNT_WIDTH, 5, width of NBITS; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
- CLK_DIV, 2, number of CLK cycles each of SCLK1, SCLK2 and LAT stays high (≥1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request; sampled only in IDLE or DONE.
- DIN  in  DATA_WIDTH  word to shift out; right-aligned, MSB of the field goes first.
- NBITS  in  CNT_WIDTH  transfer length; 0 or any value >DATA_WIDTH means DATA_WIDTH.
- DOUT  out  DATA_WIDTH  captured SI bits, right-aligned, upper bits zero.
- BUSY  out  1  high from the START acceptance edge until LAT falls.
- RDY  out  1  (ANA_RDY) high in DONE; DOUT is valid while RDY is high.
- SEL  out  1  analog chain select; high for the same window as BUSY.
- SO  out  1  (ANA_SO) serial data to the analog chain.
- SI  in  1  (ANA_SI) serial readback from the analog chain.
- SCLK1  out  1  phase-1 shift clock.
- SCLK2  out  1  phase-2 shift clock.
- LAT  out  1  latch pulse after the last bit.

Behaviour:
- All outputs are registered and glitch-free. SCLK1 and SCLK2 are never high in the same cycle.
- Reset (asynchronous, RST=1): state=IDLE; DOUT, BUSY, RDY, SEL, SO, SCLK1, SCLK2 and LAT all 0; shift register, bit counter and phase timer cleared. Reset during a transfer aborts it immediately with no LAT pulse.
- States:
  - IDLE.
  - GAPA: 1 cycle. SO is driven with the current bit.
  - PH1: CLK_DIV cycles, SCLK1=1.
  - GAPB: 1 cycle.
  - PH2: CLK_DIV cycles, SCLK2=1.
  - GAPL: 1 cycle.
  - LATCH: CLK_DIV cycles, LAT=1.
  - DONE.
- START accepted in IDLE or DONE:
  - Load the shift register with DIN; load the bit count with the effective NBITS (N).
  - Clear the capture register.
  - Set BUSY=SEL=1 and RDY=0, then go to GAPA.
- Bit order: SO = DIN[N-1] for bit 0, down to DIN[0] for the last bit. SO holds its value from GAPA through PH2.
- SI is sampled on the edge that ends the last PH2 cycle and shifted in at the LSB of the capture register. After N bits, DOUT[N-1:0] holds the bits in arrival order.
- Transitions:
  - PH2 end → GAPA if bits remain, otherwise → GAPL.
  - GAPL → LATCH.
  - LATCH end → DONE. On this transition BUSY=SEL=0, RDY=1, and DOUT is updated.
- Latency: each bit takes 2·CLK_DIV+2 cycles. RDY rises N·(2·CLK_DIV+2)+CLK_DIV+1 cycles after the START-accepting edge.
- START while BUSY is ignored, and DIN/NBITS changes during a transfer have no effect.
- START in DONE starts a new transfer; RDY drops on the accepting edge.
- Once DONE, DOUT, RDY and SO hold their values until the next START or RST.

Decomposition:
- Shared package ana_serial_pkg holds:
  - state encodings (IDLE, GAPA, PH1, GAPB, PH2, GAPL, LATCH, DONE);
  - the DATA_WIDTH/CNT_WIDTH defaults;
  - the effective-length function (0 or >DATA_WIDTH → DATA_WIDTH).
- One sub-module: ana_phase_timer, a down-counter loaded with CLK_DIV-1 that flags the last cycle of PH1, PH2 and LATCH.
- The FSM, shift register, capture register and bit counter live in the top module.

Test Plan:
- Reset: hold RST mid-run, then release → all outputs 0 and state IDLE; no SCLK activity for 20 cycles.
- CLK_DIV=2, NBITS=8, DIN=16'h00A5, SI looped to SO → SO bit sequence 1,0,1,0,0,1,0,1; exactly 8 SCLK1 and 8 SCLK2 pulses, each 2 cycles; one 2-cycle LAT pulse; RDY at cycle 51; DOUT=16'h00A5.
- NBITS=0, DIN=16'hFFFF, SI tied 1 → 16 bits transferred, SO constantly 1, DOUT=16'hFFFF, RDY at cycle 99. Repeat with NBITS=20 → identical result.
- START pulsed during PH1 of bit 2 with a different DIN → ignored, original transfer completes unchanged. START in DONE with NBITS=4, DIN=4'hC → RDY falls on the accepting edge; new DOUT=16'h000C with loopback.
- RST asserted in PH1 of bit 3 → SCLK1, SEL and BUSY go low asynchronously with no LAT pulse; the next START transfers normally.
- CLK_DIV=1 build, NBITS=3, DIN=3'b101 → 4 cycles per bit, RDY at cycle 14. Assertion over all tests that SCLK1 & SCLK2 is never 1.
